// File: rtl/reg_status_file_pkg.sv
// Shared constants for the register status file: widths, ROB sizing, opcodes.
// Optional same-cycle commit bypass is selected by defining RSF_COMMIT_BYPASS_EN.
package reg_status_file_pkg;

  localparam int ARCH_XLEN       = 32;
  localparam int ARCH_NREG       = 32;
  localparam int REG_ADDR_W      = 5;
  localparam int ROB_ENTRY_NUM   = 16;
  // Index 0 means "no producer", so the width must also cover ROB_ENTRY_NUM itself.
  localparam int ROB_ENTRY_WIDTH = $clog2(ROB_ENTRY_NUM + 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

`ifdef RSF_COMMIT_BYPASS_EN
  localparam bit COMMIT_BYPASS_EN = 1'b1;
`else
  localparam bit COMMIT_BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/reg_status_file_read_port.sv
// One decode read port: x0 forcing, optional commit bypass, and busy/value select.
// Behaviour depends on RSF_COMMIT_BYPASS_EN through the package.
module rsf_read_port
  import reg_status_file_pkg::*;
#(
  parameter int XLEN      = ARCH_XLEN,
  parameter int ROB_IDX_W = ROB_ENTRY_WIDTH,
  parameter int AW        = REG_ADDR_W
) (
  input  logic [AW-1:0]        i_addr,
  input  logic [XLEN-1:0]      i_reg_data,
  input  logic [ROB_IDX_W-1:0] i_reg_tag,
  input  logic                 i_commit_we,
  input  logic [AW-1:0]        i_commit_addr,
  input  logic [XLEN-1:0]      i_commit_data,
  input  logic [ROB_IDX_W-1:0] i_commit_tag,
  output logic [XLEN-1:0]      o_data,
  output logic [ROB_IDX_W-1:0] o_tag,
  output logic                 o_busy,
  output logic                 o_hazard
);

  logic w_busy;
  logic w_commit_hit;

  assign w_busy       = (i_reg_tag != '0);
  // The retiring instruction is the current producer of this operand.
  assign w_commit_hit = i_commit_we && (i_commit_addr != '0) &&
                        (i_commit_addr == i_addr) && (i_reg_tag == i_commit_tag);
  assign o_hazard     = !COMMIT_BYPASS_EN && w_commit_hit;

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    o_data = '0;
    o_tag  = '0;
    o_busy = 1'b0;
    if (i_addr == '0) begin
      o_data = '0;
    end else if (COMMIT_BYPASS_EN && w_commit_hit) begin
      o_data = i_commit_data;
    end else if (w_busy) begin
      o_tag  = i_reg_tag;
      o_busy = 1'b1;
    end else begin
      o_data = i_reg_data;
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename tags (ROB producer index).
// Define RSF_COMMIT_BYPASS_EN to forward commit data to reads in the commit cycle.
module reg_status_file
  import reg_status_file_pkg::*;
#(
  parameter int XLEN      = ARCH_XLEN,
  parameter int NREG      = ARCH_NREG,
  parameter int ROB_IDX_W = ROB_ENTRY_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rollback,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [ROB_IDX_W-1:0]  rs1_tag,
  output logic                  rs1_busy,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs2_data,
  output logic [ROB_IDX_W-1:0]  rs2_tag,
  output logic                  rs2_busy,
  input  logic                  rename_en,
  input  logic [REG_ADDR_W-1:0] rename_rd,
  input  logic [ROB_IDX_W-1:0]  rename_tag,
  input  logic                  commit_we,
  input  logic [REG_ADDR_W-1:0] commit_addr,
  input  logic [XLEN-1:0]       commit_data,
  input  logic [ROB_IDX_W-1:0]  commit_tag,
  output logic                  commit_hazard
);

  logic [XLEN-1:0]      r_regs [NREG];
  logic [ROB_IDX_W-1:0] r_tags [NREG];
  logic                 w_hazard1;
  logic                 w_hazard2;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this array is explicitly cleared because reads must return 0 right after reset.
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_tags[i] <= '0;
      end
    end else begin
      if (rollback) begin
        for (int i = 0; i < NREG; i++) r_tags[i] <= '0;
      end
      // A commit in the rollback cycle is architectural, so its data is kept.
      if (commit_we && (commit_addr != '0)) begin
        r_regs[commit_addr] <= commit_data;
        if (r_tags[commit_addr] == commit_tag) r_tags[commit_addr] <= '0;
      end
      // NOTE: non-blocking updates resolve in order, so a same-cycle rename overrides the commit clear.
      if (rename_en && (rename_rd != '0) && !rollback) begin
        r_tags[rename_rd] <= rename_tag;
      end
    end
  end

  rsf_read_port #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .AW(REG_ADDR_W)) u_rs1 (
    .i_addr       (rs1_addr),
    .i_reg_data   (r_regs[rs1_addr]),
    .i_reg_tag    (r_tags[rs1_addr]),
    .i_commit_we  (commit_we),
    .i_commit_addr(commit_addr),
    .i_commit_data(commit_data),
    .i_commit_tag (commit_tag),
    .o_data       (rs1_data),
    .o_tag        (rs1_tag),
    .o_busy       (rs1_busy),
    .o_hazard     (w_hazard1)
  );

  rsf_read_port #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .AW(REG_ADDR_W)) u_rs2 (
    .i_addr       (rs2_addr),
    .i_reg_data   (r_regs[rs2_addr]),
    .i_reg_tag    (r_tags[rs2_addr]),
    .i_commit_we  (commit_we),
    .i_commit_addr(commit_addr),
    .i_commit_data(commit_data),
    .i_commit_tag (commit_tag),
    .o_data       (rs2_data),
    .o_tag        (rs2_tag),
    .o_busy       (rs2_busy),
    .o_hazard     (w_hazard2)
  );

  assign commit_hazard = w_hazard1 | w_hazard2;

  a_rename_tag_nonzero: assert property (@(posedge clk) disable iff (rst)
    (rename_en && (rename_rd != '0)) |-> (rename_tag != '0));

endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: stimulus pushes expected read results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_status_file;
  import reg_status_file_pkg::*;

  localparam int TW = ROB_ENTRY_WIDTH;

`ifdef RSF_COMMIT_BYPASS_EN
  localparam bit TB_BYPASS = 1'b1;
`else
  localparam bit TB_BYPASS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            rollback;
  logic [4:0]      rs1_addr, rs2_addr;
  logic [31:0]     rs1_data, rs2_data;
  logic [TW-1:0]   rs1_tag, rs2_tag;
  logic            rs1_busy, rs2_busy;
  logic            rename_en;
  logic [4:0]      rename_rd;
  logic [TW-1:0]   rename_tag;
  logic            commit_we;
  logic [4:0]      commit_addr;
  logic [31:0]     commit_data;
  logic [TW-1:0]   commit_tag;
  logic            commit_hazard;

  always #5 clk = ~clk;

  reg_status_file dut (
    .clk(clk), .rst(rst), .rollback(rollback),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_tag(rs1_tag), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_tag(rs2_tag), .rs2_busy(rs2_busy),
    .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .commit_we(commit_we), .commit_addr(commit_addr), .commit_data(commit_data),
    .commit_tag(commit_tag), .commit_hazard(commit_hazard)
  );

  typedef struct {
    string       name;
    logic [31:0] d1;
    logic [31:0] t1;
    logic        b1;
    logic [31:0] d2;
    logic [31:0] t2;
    logic        b2;
    logic        hz;
  } exp_t;

  exp_t sb_q[$];
  logic chk_req = 1'b0;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle whenever a check is posted.
  always @(negedge clk) begin
    if (chk_req) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, ".rs1_data"}, rs1_data, e.d1);
        check({e.name, ".rs1_tag"},  32'(rs1_tag), e.t1);
        check({e.name, ".rs1_busy"}, 32'(rs1_busy), 32'(e.b1));
        check({e.name, ".rs2_data"}, rs2_data, e.d2);
        check({e.name, ".rs2_tag"},  32'(rs2_tag), e.t2);
        check({e.name, ".rs2_busy"}, 32'(rs2_busy), 32'(e.b2));
        check({e.name, ".hazard"},   32'(commit_hazard), 32'(e.hz));
      end
    end
  end

  task automatic idle();
    rollback    = 1'b0;
    rename_en   = 1'b0;
    rename_rd   = '0;
    rename_tag  = '0;
    commit_we   = 1'b0;
    commit_addr = '0;
    commit_data = '0;
    commit_tag  = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk_req = 1'b0;
    idle();
  endtask

  task automatic expect_rd(input string name,
                           input logic [31:0] d1, input logic [31:0] t1, input logic b1,
                           input logic [31:0] d2, input logic [31:0] t2, input logic b2,
                           input logic hz);
    exp_t e;
    e.name = name; e.d1 = d1; e.t1 = t1; e.b1 = b1;
    e.d2 = d2; e.t2 = t2; e.b2 = b2; e.hz = hz;
    sb_q.push_back(e);
    chk_req = 1'b1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [TW-1:0] tag);
    rename_en = 1'b1; rename_rd = rd; rename_tag = tag;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] data, input logic [TW-1:0] tag);
    commit_we = 1'b1; commit_addr = rd; commit_data = data; commit_tag = tag;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    rename(5'd3, TW'(1));            // must be overridden by reset
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // Reset state, x0 port and reset-overrides-rename
    rs1_addr = 5'd5; rs2_addr = 5'd3;
    expect_rd("reset", 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Rename x5 -> 3; the read in the same cycle still sees the old state
    rename(5'd5, TW'(3)); rs1_addr = 5'd5;
    expect_rd("pre_rename", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rs1_addr = 5'd5;
    expect_rd("renamed_x5", 0, 3, 1, 0, 0, 0, 0);
    tick();
    commit(5'd5, 32'hDEADBEEF, TW'(3)); rs1_addr = 5'd6;
    expect_rd("commit_x5_noread", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rs1_addr = 5'd5;
    expect_rd("committed_x5", 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    tick();

    // Older commit must not clear a younger rename
    rename(5'd7, TW'(2)); tick();
    rename(5'd7, TW'(4)); tick();
    commit(5'd7, 32'h11, TW'(2)); tick();
    rs1_addr = 5'd7;
    expect_rd("stale_commit_x7", 0, 4, 1, 0, 0, 0, 0);
    tick();

    // Same-cycle rename and commit: rename wins the tag, data still written
    rename(5'd9, TW'(6)); commit(5'd9, 32'h22, TW'(5)); tick();
    rs2_addr = 5'd9;
    expect_rd("same_cycle_x9", 0, 0, 0, 0, 6, 1, 0);
    tick();

    // Rollback: tags cleared, commit kept, rename dropped
    rename(5'd1, TW'(1)); tick();
    rename(5'd2, TW'(2)); tick();
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    expect_rd("pre_rollback", 0, 1, 1, 0, 2, 1, 0);
    tick();
    rollback = 1'b1; commit(5'd1, 32'h55, TW'(1)); rename(5'd3, TW'(5)); rs1_addr = 5'd4;
    expect_rd("rollback_cycle", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    expect_rd("post_rb_x1_x2", 32'h55, 0, 0, 0, 0, 0, 0);
    tick();
    rs1_addr = 5'd7; rs2_addr = 5'd9;
    expect_rd("post_rb_x7_x9", 32'h11, 0, 0, 32'h22, 0, 0, 0);
    tick();
    rs1_addr = 5'd3; rs2_addr = 5'd5;
    expect_rd("post_rb_x3_x5", 0, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    tick();

    // Writes to x0 ignored
    rename(5'd0, TW'(3)); commit(5'd0, 32'hFF, TW'(3)); rs1_addr = 5'd0;
    expect_rd("x0_write_cycle", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    expect_rd("x0_after", 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Read during matching commit: bypass or hazard depending on build
    rename(5'd5, TW'(3)); tick();
    commit(5'd5, 32'h77, TW'(3)); rs1_addr = 5'd5; rs2_addr = 5'd6;
    if (TB_BYPASS) expect_rd("commit_read_x5", 32'h77, 0, 0, 0, 0, 0, 0);
    else           expect_rd("commit_read_x5", 0, 3, 1, 0, 0, 0, 1);
    tick();
    rs1_addr = 5'd5;
    expect_rd("after_commit_x5", 32'h77, 0, 0, 0, 0, 0, 0);
    tick();

    // Non-matching commit tag on rs2: no hazard, tag kept
    rename(5'd6, TW'(7)); tick();
    commit(5'd6, 32'h99, TW'(8)); rs2_addr = 5'd6;
    expect_rd("mismatch_commit_x6", 0, 0, 0, 0, 7, 1, 0);
    tick();
    rs2_addr = 5'd6;
    expect_rd("after_mismatch_x6", 0, 0, 0, 0, 7, 1, 0);
    tick();

    // Reset overrides a concurrent commit
    rst = 1'b1; commit(5'd5, 32'hAB, TW'(0));
    @(posedge clk); #1;
    rst = 1'b0; idle();
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    expect_rd("reset_again", 0, 0, 0, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
